// File: rtl/proj4_timer_core.sv
// proj4_timer_core: saturating 0..9999 seconds countdown timer with button adds,
// switch presets, BCD digit outputs and blank/zero flags for a 7-segment driver.
module proj4_timer_core #(
    parameter int TICK_CYCLES = 100000000,
    parameter int ADD_U       = 10,
    parameter int ADD_L       = 180,
    parameter int ADD_R       = 200,
    parameter int ADD_D       = 550,
    parameter int LOAD0       = 15,
    parameter int LOAD1       = 185,
    parameter int FLASH_LIMIT = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pulse_btnu,
    input  logic        pulse_btnl,
    input  logic        pulse_btnr,
    input  logic        pulse_btnd,
    input  logic        sw0,
    input  logic        sw1,
    output logic [13:0] count,
    output logic [3:0]  bcd3,
    output logic [3:0]  bcd2,
    output logic [3:0]  bcd1,
    output logic [3:0]  bcd0,
    output logic        zero,
    output logic        blank
);
    localparam int PW = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [13:0]   count_q, count_d;
    logic [15:0]   bcd_q, bcd_d;
    logic          phase_q, phase_d;
    logic          parity_q, parity_d;
    logic          zero_q, zero_d;
    logic          blank_q, blank_d;
    logic          tick, half, load, dec;
    logic [15:0]   add, nxt;

    assign tick = presc_q == PW'(TICK_CYCLES - 1);
    assign half = presc_q == PW'(TICK_CYCLES / 2 - 1);

    always_comb begin
        load     = sw0 | sw1;
        presc_d  = (load || tick) ? '0 : presc_q + 1'b1;
        dec      = tick && count_q != 14'd0;
        add      = (pulse_btnu ? 16'(ADD_U) : 16'd0) + (pulse_btnl ? 16'(ADD_L) : 16'd0)
                 + (pulse_btnr ? 16'(ADD_R) : 16'd0) + (pulse_btnd ? 16'(ADD_D) : 16'd0);
        // 16-bit sum: 9999 + all four adds still fits before saturating
        nxt      = {2'b00, count_q} - {15'd0, dec} + add;
        count_d  = sw0 ? 14'(LOAD0) : sw1 ? 14'(LOAD1) : nxt > 16'd9999 ? 14'd9999 : nxt[13:0];
        phase_d  = load ? 1'b0 : phase_q ^ (tick | half);
        parity_d = parity_q ^ (tick & ~load);
        zero_d   = count_q == 14'd0;
        blank_d  = load ? 1'b0 :
                   count_q == 14'd0 ? phase_q :
                   count_q < 14'(FLASH_LIMIT) ? parity_q & ~phase_q : 1'b0;
        bcd_d    = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int j = 0; j < 4; j++)
                bcd_d[4*j +: 4] = bcd_d[4*j +: 4] > 4'd4 ? bcd_d[4*j +: 4] + 4'd3 : bcd_d[4*j +: 4];
            bcd_d = {bcd_d[14:0], count_q[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            count_q  <= '0;
            bcd_q    <= '0;
            phase_q  <= 1'b0;
            parity_q <= 1'b0;
            zero_q   <= 1'b1;
            blank_q  <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            count_q  <= count_d;
            bcd_q    <= bcd_d;
            phase_q  <= phase_d;
            parity_q <= parity_d;
            zero_q   <= zero_d;
            blank_q  <= blank_d;
        end
    end

    assign count = count_q;
    assign bcd3  = bcd_q[15:12];
    assign bcd2  = bcd_q[11:8];
    assign bcd1  = bcd_q[7:4];
    assign bcd0  = bcd_q[3:0];
    assign zero  = zero_q;
    assign blank = blank_q;
endmodule

// File: doc/proj4_timer_core.md
Name: proj4_timer_core

Overview:
- Decrementing seconds timer; consumes the single-cycle button pulses from the debounce/single-pulse front end.
- Each pulse adds a fixed amount of time. Switches load preset values.
- Counts down once per second and never goes below 0 or above 9999.
- Drives four BCD digits plus blank/zero flags to the 7-segment display driver.

Parameters:
- TICK_CYCLES, 100000000, clk cycles per 1-second tick; benches override it with a small value.
- ADD_U, 10, seconds added by pulse_btnu.
- ADD_L, 180, seconds added by pulse_btnl.
- ADD_R, 200, seconds added by pulse_btnr.
- ADD_D, 550, seconds added by pulse_btnd.
- LOAD0, 15, value loaded while sw0 is high.
- LOAD1, 185, value loaded while sw1 is high.
- FLASH_LIMIT, 200, nonzero counts below this value flash.

Ports:
- clk  in  1  100 MHz system clock.
- rst_n  in  1  asynchronous active-low reset.
- pulse_btnu  in  1  one-cycle add pulse (ADD_U).
- pulse_btnl  in  1  one-cycle add pulse (ADD_L).
- pulse_btnr  in  1  one-cycle add pulse (ADD_R).
- pulse_btnd  in  1  one-cycle add pulse (ADD_D).
- sw0  in  1  level; load LOAD0; active high.
- sw1  in  1  level; load LOAD1; active high.
- count  out  14  current seconds value, binary, 0..9999.
- bcd3  out  4  thousands digit.
- bcd2  out  4  hundreds digit.
- bcd1  out  4  tens digit.
- bcd0  out  4  units digit.
- zero  out  1  high when count==0.
- blank  out  1  high = display driver blanks all digits.

Behaviour:
- Clock and reset are decided: one clock, clk. Reset is asynchronous and active-low (rst_n). All state is asserted/cleared on rst_n low, independent of clk.
- Reset values: count=0, prescaler=0, bcd3..bcd0=0, zero=1, blank=0, flash phase=0.
- Prescaler:
  - Counts 0..TICK_CYCLES-1 and wraps.
  - tick is high for one cycle when the prescaler equals TICK_CYCLES-1.
  - Half-tick is high when the prescaler equals TICK_CYCLES/2-1.
- Count update, evaluated each clk in priority order:
  1. sw0 high: count<=LOAD0 and prescaler<=0. This holds every cycle while sw0 is high, so the timer is frozen at LOAD0. Pulses are ignored.
  2. Else sw1 high: same as sw0, using LOAD1.
  3. Else: next = count - dec + add.
     - dec = 1 if tick && count>0, else 0.
     - add = sum of ADD_x for every pulse high this cycle; simultaneous pulses all count.
     - If next > 9999, next = 9999.
     - Use at least 16-bit internal width; no overflow is allowed before saturation.
- Count at 0 with no pulses: stays 0. tick has no effect and there is no wrap.
- Add on the same cycle as tick: both apply, e.g. count=5 with pulse_btnu on the tick cycle gives 14.
- Latency:
  - count reflects input events 1 cycle after the event edge.
  - bcd3..bcd0, zero and blank are registered from count and lag count by 1 cycle, for 2 cycles total from the event.
- BCD: binary-to-BCD conversion of count (combinational double-dabble or equivalent feeding the output registers). Each digit is always 0..9.
- Flash phase register:
  - Toggles on every half-tick and on every tick.
  - Cleared whenever a switch load occurs.
- blank rules:
  - count==0: blank = flash phase, so 50% duty at a 1 s period.
  - 0 < count < FLASH_LIMIT: blank is high during the first half of every odd-numbered second. Seconds are counted by a 1-bit second parity that toggles on tick; blank = parity & ~phase.
  - count >= FLASH_LIMIT: blank=0.
  - Any switch high: blank=0.
- Reset mid-operation: immediate return to reset values. The prescaler restarts, so the first tick after release is TICK_CYCLES cycles later.
- Pulses longer than one cycle are illegal input; each high cycle adds once.

Test Plan:
1. TICK_CYCLES=10, reset, then pulse_btnu at cycle 3 → count=10 at cycle 4; bcd1=1, bcd0=0 at cycle 5; after 10 further ticks count=0 and zero=1, and stays 0 for 5 more ticks.
2. sw1 high for 4 cycles then low → count=185 throughout and pulses during the window are ignored; first decrement to 184 exactly TICK_CYCLES cycles after sw1 falls.
3. count=9900, pulse_btnd → count=9999 (saturated), bcd=9,9,9,9; all four pulses on one cycle from count=0 → 940.
4. count=1, pulse_btnl coincident with tick → count=180; count=0 with pulse_btnu on a tick cycle → 10, not 9.
5. count=0, run 40 cycles → blank toggles every 5 cycles; count=150 → blank high only during the first half of alternate seconds; count=250 → blank stays 0.
6. Assert rst_n low asynchronously mid-countdown (between clk edges) → count=0, bcd=0, zero=1, blank=0 immediately; sw0 held during release → count=15 on the first clk after release.
